// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and dispatch: a circular FIFO of {inst, pc}
// presenting its head as a show-ahead IF/ID packet, squashed on rollback.
package fetch_queue_pkg;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
    } if_id_packet_t;
endpackage

`ifndef NOP
`define NOP 32'h0000_0013
`endif

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fetch_valid,
    input  logic [31:0]         fetch_inst,
    input  logic [31:0]         fetch_pc,
    output logic                fetch_ready,
    input  logic                stall,
    input  logic                rollback,
    output if_id_packet_t       if_id_packet,
    output logic [CNT_W-1:0]    count,
    output logic                overflow_err
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;
    logic             out_of_reset;
    logic             full;
    logic             head_valid;
    logic             enq;
    logic             pop;

    // out_of_reset keeps fetch_ready low until the first edge after reset releases
    assign full        = (count_q == CNT_W'(DEPTH));
    assign fetch_ready = out_of_reset && !full && !rollback;
    assign head_valid  = (count_q != '0) && !rollback;
    assign enq         = fetch_valid && fetch_ready;
    assign pop         = head_valid && !stall;
    assign count       = count_q;

    always_comb begin
        if_id_packet.inst  = `NOP;
        if_id_packet.pc    = '0;
        if_id_packet.npc   = '0;
        if_id_packet.valid = 1'b0;
        if (head_valid) begin
            if_id_packet.inst  = inst_mem[head];
            if_id_packet.pc    = pc_mem[head];
            if_id_packet.npc   = pc_mem[head] + 32'd4;
            if_id_packet.valid = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            inst_mem[tail] <= fetch_inst;
            pc_mem[tail]   <= fetch_pc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count_q      <= '0;
            overflow_err <= 1'b0;
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            if (fetch_valid && full && !rollback)
                overflow_err <= 1'b1;
            if (rollback) begin
                head    <= '0;
                tail    <= '0;
                count_q <= '0;
            end else begin
                if (enq)
                    tail <= tail + PTR_W'(1);
                if (pop)
                    head <= head + PTR_W'(1);
                case ({enq, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/overflow, drain, streaming wrap, rollback and
// asynchronous reset, each checked against hand-computed values.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          fetch_valid = 1'b0;
    logic [31:0]   fetch_inst = '0;
    logic [31:0]   fetch_pc = '0;
    logic          fetch_ready;
    logic          stall = 1'b0;
    logic          rollback = 1'b0;
    if_id_packet_t if_id_packet;
    logic [3:0]    count;
    logic          overflow_err;

    int checks = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .fetch_valid  (fetch_valid),
        .fetch_inst   (fetch_inst),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .stall        (stall),
        .rollback     (rollback),
        .if_id_packet (if_id_packet),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one edge and land 1 time unit after it, where inputs are changed
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // ---- reset, then fill with stall held ----
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(if_id_packet.valid), 0);
        check("rst_ready", 32'(fetch_ready), 0);
        check("rst_inst", if_id_packet.inst, NOP_INST);
        reset = 1'b1;
        #1;
        check("ready_before_first_edge", 32'(fetch_ready), 0);
        tick();
        check("ready_after_first_edge", 32'(fetch_ready), 1);
        stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fetch_valid = 1'b1;
            fetch_pc    = 32'(4 * i);
            fetch_inst  = 32'hA000_0000 + 32'(i);
            #1;
            check("fill_count", 32'(count), 32'(i));
            check("fill_ready", 32'(fetch_ready), 1);
            if (i > 0) begin
                check("fill_head_pc", if_id_packet.pc, 0);
                check("fill_head_npc", if_id_packet.npc, 4);
                check("fill_head_valid", 32'(if_id_packet.valid), 1);
            end
            tick();
        end
        fetch_pc   = 32'h20;
        fetch_inst = 32'hA000_0008;
        #1;
        check("full_count", 32'(count), 8);
        check("full_ready", 32'(fetch_ready), 0);
        check("full_head_pc", if_id_packet.pc, 0);
        check("full_no_ovf_yet", 32'(overflow_err), 0);
        tick();
        check("ovf_set", 32'(overflow_err), 1);
        check("ovf_count", 32'(count), 8);

        // ---- drain ----
        fetch_valid = 1'b0;
        stall       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("drain_pc", if_id_packet.pc, 32'(4 * i));
            check("drain_inst", if_id_packet.inst, 32'hA000_0000 + 32'(i));
            check("drain_valid", 32'(if_id_packet.valid), 1);
            tick();
        end
        #1;
        check("empty_valid", 32'(if_id_packet.valid), 0);
        check("empty_inst", if_id_packet.inst, NOP_INST);
        check("empty_pc", if_id_packet.pc, 0);
        check("empty_npc", if_id_packet.npc, 0);
        check("empty_count", 32'(count), 0);

        // ---- streaming at count==1 across pointer wrap ----
        fetch_valid = 1'b1;
        fetch_pc    = 32'h200;
        fetch_inst  = 32'hB000_0000;
        tick();
        for (int i = 0; i < 20; i++) begin
            fetch_pc   = 32'h204 + 32'(4 * i);
            fetch_inst = 32'hB000_0001 + 32'(i);
            #1;
            check("stream_count", 32'(count), 1);
            check("stream_pc", if_id_packet.pc, 32'h200 + 32'(4 * i));
            check("stream_inst", if_id_packet.inst, 32'hB000_0000 + 32'(i));
            tick();
        end
        fetch_valid = 1'b0;
        #1;
        check("stream_last_pc", if_id_packet.pc, 32'h250);
        tick();
        check("stream_drained", 32'(count), 0);

        // ---- rollback with 5 entries ----
        stall       = 1'b1;
        fetch_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_pc   = 32'h300 + 32'(4 * i);
            fetch_inst = 32'hC000_0000 + 32'(i);
            tick();
        end
        check("rb_pre_count", 32'(count), 5);
        rollback   = 1'b1;
        stall      = 1'b0;
        fetch_pc   = 32'h400;
        fetch_inst = 32'hDEAD_0000;
        #1;
        check("rb_valid", 32'(if_id_packet.valid), 0);
        check("rb_ready", 32'(fetch_ready), 0);
        tick();
        rollback    = 1'b0;
        fetch_valid = 1'b0;
        #1;
        check("rb_count", 32'(count), 0);
        check("rb_valid_after", 32'(if_id_packet.valid), 0);
        check("rb_ovf_kept", 32'(overflow_err), 1);
        fetch_valid = 1'b1;
        fetch_pc    = 32'h500;
        fetch_inst  = 32'hE000_0000;
        tick();
        fetch_valid = 1'b0;
        #1;
        check("rb_new_head_pc", if_id_packet.pc, 32'h500);
        check("rb_new_head_inst", if_id_packet.inst, 32'hE000_0000);
        check("rb_new_count", 32'(count), 1);

        // ---- async reset mid-operation ----
        stall       = 1'b1;
        fetch_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fetch_pc = 32'h600 + 32'(4 * i);
            tick();
        end
        fetch_valid = 1'b0;
        #1;
        check("ar_pre_count", 32'(count), 3);
        #1;
        reset = 1'b0;
        #1;
        check("ar_count", 32'(count), 0);
        check("ar_valid", 32'(if_id_packet.valid), 0);
        check("ar_ovf", 32'(overflow_err), 0);
        check("ar_ready", 32'(fetch_ready), 0);
        #1;
        reset = 1'b1;
        #1;
        check("ar_ready_held", 32'(fetch_ready), 0);
        tick();
        fetch_valid = 1'b1;
        fetch_pc    = 32'h100;
        fetch_inst  = 32'hF000_0000;
        tick();
        fetch_pc    = 32'hFFFF_FFFC;
        fetch_inst  = 32'hF000_0001;
        #1;
        check("ar_enq_pc", if_id_packet.pc, 32'h100);
        check("ar_enq_npc", if_id_packet.npc, 32'h104);
        check("ar_enq_valid", 32'(if_id_packet.valid), 1);
        stall = 1'b0;
        tick();
        fetch_valid = 1'b0;
        #1;
        check("npc_wrap_pc", if_id_packet.pc, 32'hFFFF_FFFC);
        check("npc_wrap", if_id_packet.npc, 32'h0);
        check("npc_wrap_count", 32'(count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- In-order instruction buffer between the fetch stage and dispatch.
- Accepts one fetched instruction per cycle and holds it in a circular FIFO.
- Presents the head entry to dispatch as an IF_ID_PACKET and pops it when dispatch does not stall.
- Flushed entirely on branch-mispredict rollback. It is the producing end of the IF_ID_PACKET/stall interface that dispatch consumes.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; the queue is held in reset while reset==0.
- fetch_valid  input  1  fetch is offering an instruction this cycle.
- fetch_inst  input  32  offered instruction word.
- fetch_pc  input  32  PC of the offered instruction.
- fetch_ready  output  1  queue can accept an entry this cycle.
- stall  input  1  dispatch cannot consume the head this cycle.
- rollback  input  1  squash all buffered instructions.
- if_id_packet  output  IF_ID_PACKET  head entry to dispatch: inst, PC, NPC, valid.
- count  output  CNT_W  current occupancy.
- overflow_err  output  1  sticky error flag.

Behaviour:
- Storage and pointers:
  - DEPTH entries of {inst, PC}.
  - head and tail pointers of $clog2(DEPTH) bits each; wrap modulo DEPTH.
  - count register of CNT_W bits.
- Reset (reset==0, asynchronous): head=0, tail=0, count=0, overflow_err=0.
  - Outputs during reset: fetch_ready=0, if_id_packet.valid=0, if_id_packet.inst=`NOP, PC=0, NPC=0.
  - fetch_ready=0 is held until the first edge after reset deasserts.
  - Reset may assert at any time; in-flight entries are discarded.
- fetch_ready = (count < DEPTH) && !rollback.
  - Derived from registered count only. A simultaneous pop does not free a slot in the same cycle.
- Enqueue: fetch_valid && fetch_ready.
  - Writes the entry at tail; tail increments at the clock edge.
- Dispatch output (show-ahead, combinational from the head entry):
  - if_id_packet.valid = (count != 0) && !rollback.
  - inst and PC = head entry; NPC = PC + 4 (32-bit, wraps).
  - When valid==0: inst=`NOP, PC=0, NPC=0.
- Pop: if_id_packet.valid && !stall; head increments at the clock edge.
- Simultaneous enqueue and pop:
  - count is unchanged; both pointers advance.
  - If count==1, the new entry becomes the head in the next cycle with no bubble.
- Count update: count_next = count + enq - pop.
- Rollback (single-cycle pulse or held):
  - Holding rollback for multiple cycles keeps the queue empty.
  - In the rollback cycle, no enqueue or pop occurs.
  - At the edge: head=tail=0, count=0.
  - if_id_packet.valid is already 0 in the rollback cycle.
  - rollback takes priority over stall, fetch_valid and pop.
- Overflow: fetch_valid==1 while count==DEPTH and rollback==0 sets overflow_err=1.
  - The offered instruction is dropped.
  - overflow_err stays 1 until reset; rollback does not clear it.
- Ordering: instructions leave in exactly the order accepted. No reordering; no duplication except by an external re-offer.
- Latency: an instruction accepted at edge N is visible on if_id_packet from edge N onward, i.e. from cycle N+1, if the queue was empty.

Test Plan:
1. Reset then fill: fetch_valid=1 for 8 cycles, PCs 0x0,0x4,...,0x1C, stall=1.
   - count reaches 8; fetch_ready=0.
   - if_id_packet holds PC=0x0, NPC=0x4, valid=1 throughout.
   - A 9th offer sets overflow_err=1.
2. Drain: after case 1, stall=0, fetch_valid=0.
   - PCs 0x0..0x1C appear on consecutive cycles, one per cycle.
   - Then valid=0, inst=`NOP, count=0.
3. Streaming: count=1, fetch_valid=1 and stall=0 every cycle for 20 cycles.
   - count stays 1; one instruction pops per cycle in order.
   - Pointers wrap past 7 with no loss.
4. Rollback: queue holds 5 entries; assert rollback for 1 cycle with fetch_valid=1 and stall=0.
   - In that cycle valid=0 and fetch_ready=0.
   - Next cycle count=0; the offered instruction is not stored.
   - overflow_err is unchanged.
5. Asynchronous reset mid-operation: queue holds 3 entries and overflow_err=1; drive reset=0 between clock edges.
   - Immediately count=0, valid=0, overflow_err=0, fetch_ready=0.
   - After release, an enqueue of PC=0x100 appears with NPC=0x104.
